// File: rtl/rotator_pkg.sv
// Shared constants for the rotator unit: operation modes, directions and FSM state encoding.
package rotator_pkg;

    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_LSH = 2'b01;
    localparam logic [1:0] MODE_ASH = 2'b10;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rotator_step.sv
// Combinational one-step barrel function: rotate / logical shift / arithmetic shift.
// Ports:
//   value  - word to be stepped
//   amt    - bit positions to move (0 holds the value)
//   dir    - 1 = left (toward MSB), 0 = right
//   mode   - 00 rotate, 01 logical, 10 arithmetic, 11 treated as rotate
//   result - stepped word
module rotator_step
    import rotator_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] rot_r;

    // Rotation via a doubled word: shifting {v,v} leaves the rotated word in one half.
    always_comb begin
        dbl    = {value, value};
        rot_l  = dbl << amt;
        rot_r  = dbl >> amt;
        result = value;
        case (mode)
            MODE_LSH: result = (dir == DIR_LEFT) ? (value << amt) : (value >> amt);
            MODE_ASH: result = (dir == DIR_LEFT) ? (value << amt)
                                                 : WIDTH'($signed(value) >>> amt);
            default:  result = (dir == DIR_LEFT) ? rot_l[2*WIDTH-1:WIDTH] : rot_r[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/rotator_unit_param.sv
// Job-based multi-cycle rotator/shifter with valid/ready input and output ports.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - job handshake (in_ready high only in IDLE)
//   in_data               - initial register value
//   in_amt, in_dir,
//   in_mode, in_steps     - operation descriptor
//   out_valid/out_ready   - result handshake
//   out_data              - final result (valid with out_valid)
//   busy                  - high in RUN or DONE
//   rotated_out           - live register contents
module rotator_unit_param
    import rotator_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 1,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned AMT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic [CNT_W-1:0] in_steps,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [WIDTH-1:0] rotated_out
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   step_val;

    rotator_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .value  (data_q),
        .amt    (amt_q),
        .dir    (dir_q),
        .mode   (mode_q),
        .result (step_val)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= WIDTH'(RESET_VAL);
            cnt_q   <= '0;
            amt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            mode_q  <= MODE_ROT;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            amt_q   <= amt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        amt_d   = amt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    amt_d   = in_amt;
                    dir_d   = in_dir;
                    mode_d  = in_mode;
                    cnt_d   = in_steps;
                    state_d = (in_steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                data_d = step_val;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign out_data    = data_q;
    assign rotated_out = data_q;

endmodule

// File: doc/rotator_unit_param.md
# rotator_unit_param

Parametrised, job-based successor to the free-running 8-bit rotator. Accepts a load word plus an operation descriptor (direction, mode, per-step amount, step count) over a valid/ready handshake. It applies the operation one step per clock, exposes the live register every cycle, and presents the final word on a valid/ready output port. It sits in the datapath wherever a bit-field rotation or shift must run over multiple cycles with flow control.

## Interface
Parameters:
- WIDTH, 8: data width in bits; minimum 2.
- RESET_VAL, 1: register value after reset; truncated to WIDTH.
- CNT_W, 8: width of the step-count field.
- AMT_W, $clog2(WIDTH): derived width of the per-step amount; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  block can accept a job; high only in IDLE
- in_data  in  WIDTH  initial register value
- in_amt  in  AMT_W  bit positions moved per step; 0 means the step holds the value
- in_dir  in  1  1 = left (toward MSB), 0 = right
- in_mode  in  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved (behaves as rotate)
- in_steps  in  CNT_W  number of steps; 0 = pass-through
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_data  out  WIDTH  final result; equals the register when out_valid is high, otherwise don't-care
- busy  out  1  high in RUN or DONE
- rotated_out  out  WIDTH  live register contents every cycle

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - reg <= in_data.
  - dir, mode, amt and cnt <= in_steps are latched.
  - The next state is RUN if in_steps != 0, otherwise DONE.
- RUN: each cycle applies one step (reg <= step(reg)) and decrements cnt. When cnt == 1, the final step is applied and the FSM goes to DONE.
- DONE: out_valid = 1. On out_ready, the FSM returns to IDLE. reg holds its value until the next load.
- Step function:
  - Rotate: circular move by amt in dir.
  - Logical shift: vacated bits are filled with 0.
  - Arithmetic shift right: vacated bits are filled with the current MSB.
  - Arithmetic shift left: identical to a logical shift left.
- Repeated shifts may drain the register to all-zero (logical) or all-sign (arithmetic). This is legal, not an error.
- in_valid while not IDLE is ignored. The producer must hold the job until in_ready.

## Timing
- Reset, applied immediately and asynchronously:
  - reg = RESET_VAL; state = IDLE; cnt = 0.
  - in_ready = 1, out_valid = 0, busy = 0, rotated_out = RESET_VAL.
- Acceptance edge E0: after E0, rotated_out = in_data and busy = 1.
- After edge Ek (1 ≤ k ≤ N), rotated_out holds the value after k steps.
- out_valid is first high in the cycle after edge EN: N+1 cycles after the acceptance cycle. For N = 0 it is high 1 cycle after acceptance.
- The earliest next acceptance is the cycle after the out_valid && out_ready handshake. There are no back-to-back jobs: throughput is 1 job per N+2 cycles.
- out_valid, out_data and rotated_out are stable while out_ready is low.
- Reset mid-RUN or mid-DONE aborts the job. No completion is produced after reset is released.
- All outputs are driven from registers or decoded from state. There are no combinational input-to-output paths except none on in_ready (state only).

## Structure
- Package rotator_pkg holds:
  - Mode constants: MODE_ROT = 2'b00, MODE_LSH = 2'b01, MODE_ASH = 2'b10.
  - The state encoding: IDLE, RUN, DONE.
  - The direction constants: DIR_LEFT = 1, DIR_RIGHT = 0.
- Sub-module rotator_step is the combinational one-step barrel function:
  - Inputs: value, amt, dir, mode. Output: the stepped value. Parameterised by WIDTH.
  - It is instantiated once; the top holds the FSM, counter and registers.

## Test plan
WIDTH = 8, RESET_VAL = 8'h01 throughout.
- Reset: hold rst for 2 cycles, then release. Expect rotated_out = 8'h01, in_ready = 1, out_valid = 0 and busy = 0, both during reset and after release.
- Full left rotation: data 8'h01, dir 1, mode 00, amt 1, steps 8.
  - rotated_out goes 01, 02, 04 … 80, 01.
  - out_valid rises 9 cycles after acceptance with out_data 8'h01.
- Multi-bit right rotation: data 8'hB1, dir 0, amt 3, steps 1. Expect out_data 8'h36, 2 cycles after acceptance.
- Shift modes: data 8'h80, dir 0, amt 2, steps 3.
  - Arithmetic: 80, E0, F8, FE; final 8'hFE.
  - Logical: 20, 08, 02; final 8'h02.
- Backpressure and pass-through: data 8'h5A, steps 0, out_ready low for 5 cycles.
  - out_valid is high from cycle 1 and out_data = 5A holds.
  - in_ready stays 0, and a second in_valid is ignored.
  - After out_ready is raised, in_ready returns the next cycle.
- Reset mid-operation: start an 8-step rotate, then assert rst at step 3. Expect rotated_out = 01 and out_valid = 0 immediately, and no out_valid after release.
